urv_dm_wb_bridge: RTL and testbench
===================================

Name: urv_dm_wb_bridge

Overview:
Data-memory bus bridge directly downstream of the uRV core's data memory port. It converts the core's load/store requests into single Wishbone B4 pipelined classic-cycle transactions, one transaction at a time. It returns load data and one-cycle done pulses to the core's writeback interface. It also records bus errors in a sticky status register.

Parameters:
g_timeout_cycles, 255, number of WAIT/REQ cycles without ack/err before a forced error (used only with the optional feature); range 1..65535.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
dm_addr_i  in  32  request address from core
dm_data_s_i  in  32  store data
dm_data_select_i  in  4  byte lane select
dm_load_i  in  1  load request (sampled only when dm_ready_o=1)
dm_store_i  in  1  store request (sampled only when dm_ready_o=1)
dm_ready_o  out  1  bridge idle, request accepted this cycle
dm_data_l_o  out  32  load data, valid while dm_load_done_o=1
dm_load_done_o  out  1  one-cycle load completion pulse
dm_store_done_o  out  1  one-cycle store completion pulse
wb_adr_o  out  32  Wishbone address
wb_dat_o  out  32  Wishbone write data
wb_sel_o  out  4  Wishbone byte select
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_dat_i  in  32  Wishbone read data
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  bus error
wb_stall_i  in  1  slave stall
bus_err_clr_i  in  1  clear sticky error
bus_err_o  out  1  sticky bus error flag
bus_err_addr_o  out  32  address of first error since last clear

Behaviour:
- Reset values (async on rst_i=0): state IDLE; all outputs 0 except dm_ready_o=1; wb_* outputs 0; dm_data_l_o=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE: dm_ready_o=1. On dm_store_i or dm_load_i, latch addr/data/sel/we and go to REQ. If both are asserted, store wins and the load is dropped.
- REQ: cyc=1, stb=1.
  - wb_stall_i=0 with no ack/err: go to WAIT.
  - wb_stall_i=0 with ack or err in the same cycle: go to IDLE directly.
- WAIT: cyc=1, stb=0. On ack or err, go to IDLE.
- Completion, registered:
  - Done pulse (load_done or store_done per latched we) is asserted in the cycle after ack/err.
  - dm_data_l_o = wb_dat_i captured on ack, or 0 on err.
  - dm_ready_o=1 in that same cycle, so a new request is accepted (back-to-back).
- ack and err together: treated as err.
- Minimum latency is 2 cycles from request to done pulse (request, REQ with immediate ack, done).
- Requests while dm_ready_o=0 are ignored. A bench assertion flags them as protocol violations.
- Error register:
  - On err completion: bus_err_o<=1. bus_err_addr_o<=latched addr only if bus_err_o was 0.
  - bus_err_clr_i clears both.
  - Clear in the same cycle as a new error: the error wins and the address is captured.
- Reset mid-transaction: cyc/stb drop asynchronously and no done pulse is generated. A late ack after reset is ignored (state IDLE).
- Stray ack/err in IDLE: ignored.

Optional Feature:
URV_DM_BRIDGE_TIMEOUT_EN:
- Defined:
  - 16-bit counter, cleared on entry to REQ, increments each cycle in REQ/WAIT.
  - On reaching g_timeout_cycles without ack/err: abort (cyc/stb low next cycle), complete as err, set the error flag.
- Undefined: the counter is absent, the bridge waits indefinitely, and g_timeout_cycles is ignored.

Decomposition:
- Shared urv_defs.v holds the FSM state encodings (`URV_DMB_IDLE/REQ/WAIT`) and the error load value constant (32'h0).
- One natural sub-module: urv_bus_timeout (counter + expiry flag, start/clear/enable inputs). It is instantiated only under URV_DM_BRIDGE_TIMEOUT_EN.

Test Plan:
- Load with zero-wait slave: dm_load_i, addr 0x100, slave acks the REQ cycle with 0xCAFEF00D -> dm_load_done_o pulses one cycle, 2 cycles after request, dm_data_l_o=0xCAFEF00D, wb_we_o=0.
- Store with stall: store 0x12345678 to 0x200, sel 4'b0011, wb_stall_i high 3 cycles, ack 2 cycles after stb accepted -> stb high exactly 4 cycles, wb_dat_o/wb_sel_o stable, one dm_store_done_o pulse.
- Back-to-back: new load issued in the done cycle of a store -> accepted, second transaction stb 1 cycle later, no lost or duplicate pulses.
- Error: load to 0xBAD0 answered by wb_err_i -> dm_load_done_o with data 0, bus_err_o=1, bus_err_addr_o=0xBAD0. A second error at 0xBAD4 leaves addr 0xBAD0. bus_err_clr_i together with a third error at 0xBAD8 -> bus_err_o=1, addr=0xBAD8.
- Timeout (macro on, g_timeout_cycles=8): slave never acks -> cyc drops after 8 cycles, done pulse with data 0, bus_err_o=1. With macro off -> cyc stays high for 1000 cycles.
- Reset mid-WAIT: rst_i low during WAIT, ack arrives after release -> wb_cyc_o=0 immediately on reset, no done pulse, dm_ready_o=1.

Source files
------------

// File: rtl/urv_dm_wb_bridge_pkg.sv
// Shared definitions for the uRV data-memory Wishbone bridge: FSM encodings,
// the load value returned on a bus error, and the latched request record.
package urv_dm_wb_bridge_pkg;

    localparam logic [1:0] URV_DMB_IDLE = 2'd0;
    localparam logic [1:0] URV_DMB_REQ  = 2'd1;
    localparam logic [1:0] URV_DMB_WAIT = 2'd2;

    localparam logic [31:0] URV_DMB_ERR_LOAD_VALUE = 32'h0;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } dm_req_t;

endpackage

// File: rtl/urv_dm_wb_bridge_if.sv
// Wishbone B4 pipelined bus between the data-memory bridge (master) and the
// memory/peripheral fabric (slave).
interface urv_dm_wb_bridge_if;

    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_stall_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
    );

endinterface

// File: rtl/urv_bus_timeout.sv
// Bus transaction watchdog: counts cycles while enabled and flags expiry after
// g_timeout_cycles. Only built when URV_DM_BRIDGE_TIMEOUT_EN is defined.
`ifdef URV_DM_BRIDGE_TIMEOUT_EN
module urv_bus_timeout #(
    parameter int g_timeout_cycles = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] c_limit = 16'(g_timeout_cycles - 1);

    logic [15:0] count;

    // Count holds at the limit so a stuck enable cannot wrap into a fresh window.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= 16'd0;
        end else if (start || clear) begin
            count <= 16'd0;
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

    assign expired = enable && (count == c_limit);

endmodule
`endif

// File: rtl/urv_dm_wb_bridge.sv
// uRV data-memory port to Wishbone B4 pipelined bridge, one transaction at a time,
// with sticky bus-error capture. Optional watchdog: define URV_DM_BRIDGE_TIMEOUT_EN.
module urv_dm_wb_bridge
    import urv_dm_wb_bridge_pkg::*;
#(
    parameter int g_timeout_cycles = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic [31:0]              dm_addr_i,
    input  logic [31:0]              dm_data_s_i,
    input  logic [3:0]               dm_data_select_i,
    input  logic                     dm_load_i,
    input  logic                     dm_store_i,
    output logic                     dm_ready_o,
    output logic [31:0]              dm_data_l_o,
    output logic                     dm_load_done_o,
    output logic                     dm_store_done_o,

    urv_dm_wb_bridge_if.master       wb,

    input  logic                     bus_err_clr_i,
    output logic                     bus_err_o,
    output logic [31:0]              bus_err_addr_o
);

    // state | meaning
    // IDLE  | ready for a core request; may be the cycle carrying a done pulse
    // REQ   | cyc+stb asserted, waiting for the slave to take the strobe
    // WAIT  | strobe accepted, cyc held until ack/err

    logic [1:0] state;
    logic [1:0] state_nxt;
    dm_req_t    req;
    logic       accept;
    logic       bus_done;
    logic       timed_out;
    logic       finish;
    logic       fault;

    assign accept   = (state == URV_DMB_IDLE) && (dm_load_i || dm_store_i);
    assign bus_done = (((state == URV_DMB_REQ) && !wb.wb_stall_i) || (state == URV_DMB_WAIT))
                      && (wb.wb_ack_i || wb.wb_err_i);
    assign finish   = bus_done || timed_out;
    assign fault    = (bus_done && wb.wb_err_i) || timed_out;

`ifdef URV_DM_BRIDGE_TIMEOUT_EN
    urv_bus_timeout #(
        .g_timeout_cycles (g_timeout_cycles)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (accept),
        .clear   (finish),
        .enable  (state != URV_DMB_IDLE),
        .expired (timed_out)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (g_timeout_cycles != 0);
    assign timed_out          = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            URV_DMB_IDLE: if (accept) state_nxt = URV_DMB_REQ;
            URV_DMB_REQ: begin
                if (finish)
                    state_nxt = URV_DMB_IDLE;
                else if (!wb.wb_stall_i)
                    state_nxt = URV_DMB_WAIT;
            end
            URV_DMB_WAIT: if (finish) state_nxt = URV_DMB_IDLE;
            default:      state_nxt = URV_DMB_IDLE;
        endcase
    end

    // Store has priority when the core raises both strobes; the load is dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state           <= URV_DMB_IDLE;
            req             <= '0;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            dm_data_l_o     <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req.adr <= dm_addr_i;
                req.dat <= dm_data_s_i;
                req.sel <= dm_data_select_i;
                req.we  <= dm_store_i;
            end
            dm_load_done_o  <= finish && !req.we;
            dm_store_done_o <= finish && req.we;
            if (finish && !req.we)
                dm_data_l_o <= fault ? URV_DMB_ERR_LOAD_VALUE : wb.wb_dat_i;
        end
    end

    // A new error beats a simultaneous clear so that no fault is ever lost.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus_err_o      <= 1'b0;
            bus_err_addr_o <= 32'h0;
        end else if (finish && fault) begin
            bus_err_o <= 1'b1;
            if (!bus_err_o || bus_err_clr_i)
                bus_err_addr_o <= req.adr;
        end else if (bus_err_clr_i) begin
            bus_err_o      <= 1'b0;
            bus_err_addr_o <= 32'h0;
        end
    end

    assign dm_ready_o  = (state == URV_DMB_IDLE);
    assign wb.wb_cyc_o = (state != URV_DMB_IDLE);
    assign wb.wb_stb_o = (state == URV_DMB_REQ);
    assign wb.wb_adr_o = req.adr;
    assign wb.wb_dat_o = req.dat;
    assign wb.wb_sel_o = req.sel;
    assign wb.wb_we_o  = req.we;

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// Self-checking bench for urv_dm_wb_bridge: directed scenarios plus randomized
// transactions scored against a transaction-level timing and error model.
module tb_urv_dm_wb_bridge;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_load_i;
    logic        dm_store_i;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic        bus_err_clr_i;
    logic        bus_err_o;
    logic [31:0] bus_err_addr_o;

    urv_dm_wb_bridge_if wb_bus ();

    urv_dm_wb_bridge #(
        .g_timeout_cycles (8)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_load_i        (dm_load_i),
        .dm_store_i       (dm_store_i),
        .dm_ready_o       (dm_ready_o),
        .dm_data_l_o      (dm_data_l_o),
        .dm_load_done_o   (dm_load_done_o),
        .dm_store_done_o  (dm_store_done_o),
        .wb               (wb_bus),
        .bus_err_clr_i    (bus_err_clr_i),
        .bus_err_o        (bus_err_o),
        .bus_err_addr_o   (bus_err_addr_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic        m_err      = 1'b0;
    logic [31:0] m_err_addr = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Core must only raise a request while the bridge is ready.
    always @(negedge clk) begin
        if (rst_i && (dm_load_i || dm_store_i))
            chk("proto_req_while_busy", 32'(dm_ready_o), 1);
    end

    // One full transaction: s stall cycles, then the strobe is taken, then the
    // slave answers d cycles later (d=0 means in the accepting cycle).
    // Returns at the sample point of the cycle that must carry the done pulse.
    task automatic run_txn(input int ld, input int st, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel,
                           input int s, input int d, input int er, input int with_ack,
                           input logic [31:0] rdata, input int clr);
        int   last;
        logic we;
        we   = (st != 0);
        last = s + 1 + d;
        dm_addr_i        = addr;
        dm_data_s_i      = wdata;
        dm_data_select_i = sel;
        dm_load_i        = (ld != 0);
        dm_store_i       = we;
        step();
        dm_load_i  = 1'b0;
        dm_store_i = 1'b0;
        for (int k = 1; k <= last; k++) begin
            if (k > 1) step();
            chk("txn_cyc", 32'(wb_bus.wb_cyc_o), 1);
            chk("txn_stb", 32'(wb_bus.wb_stb_o), 32'(k <= s + 1));
            chk("txn_ready", 32'(dm_ready_o), 0);
            chk("txn_no_done", 32'({dm_load_done_o, dm_store_done_o}), 0);
            chk("txn_adr", wb_bus.wb_adr_o, addr);
            chk("txn_dat", wb_bus.wb_dat_o, wdata);
            chk("txn_sel", 32'(wb_bus.wb_sel_o), 32'(sel));
            chk("txn_we", 32'(wb_bus.wb_we_o), 32'(we));
            wb_bus.wb_stall_i = (k <= s);
            if (k == last) begin
                wb_bus.wb_ack_i = (er == 0) || (with_ack != 0);
                wb_bus.wb_err_i = (er != 0);
                wb_bus.wb_dat_i = rdata;
                bus_err_clr_i   = (clr != 0);
            end else begin
                wb_bus.wb_ack_i = 1'b0;
                wb_bus.wb_err_i = 1'b0;
                wb_bus.wb_dat_i = $urandom();
            end
        end
        step();
        wb_bus.wb_ack_i   = 1'b0;
        wb_bus.wb_err_i   = 1'b0;
        wb_bus.wb_stall_i = 1'b0;
        bus_err_clr_i     = 1'b0;
        if (er != 0) begin
            if (!m_err || clr != 0) m_err_addr = addr;
            m_err = 1'b1;
        end else if (clr != 0) begin
            m_err      = 1'b0;
            m_err_addr = 32'h0;
        end
        chk("end_cyc", 32'(wb_bus.wb_cyc_o), 0);
        chk("end_stb", 32'(wb_bus.wb_stb_o), 0);
        chk("end_ready", 32'(dm_ready_o), 1);
        chk("end_load_done", 32'(dm_load_done_o), 32'(!we));
        chk("end_store_done", 32'(dm_store_done_o), 32'(we));
        if (!we) chk("end_load_data", dm_data_l_o, (er != 0) ? 32'h0 : rdata);
        chk("end_bus_err", 32'(bus_err_o), 32'(m_err));
        chk("end_bus_err_addr", bus_err_addr_o, m_err_addr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ld, st, s, d, er, wa, clr, stray, hold;
        rst_i             = 1'b0;
        dm_addr_i         = 32'h0;
        dm_data_s_i       = 32'h0;
        dm_data_select_i  = 4'h0;
        dm_load_i         = 1'b0;
        dm_store_i        = 1'b0;
        bus_err_clr_i     = 1'b0;
        wb_bus.wb_dat_i   = 32'h0;
        wb_bus.wb_ack_i   = 1'b0;
        wb_bus.wb_err_i   = 1'b0;
        wb_bus.wb_stall_i = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(dm_ready_o), 1);
        chk("rst_cyc", 32'(wb_bus.wb_cyc_o), 0);
        chk("rst_stb", 32'(wb_bus.wb_stb_o), 0);
        chk("rst_done", 32'({dm_load_done_o, dm_store_done_o}), 0);
        chk("rst_data_l", dm_data_l_o, 0);
        chk("rst_adr", wb_bus.wb_adr_o, 0);
        chk("rst_bus_err", 32'(bus_err_o), 0);
        rst_i = 1'b1;
        step();

        // Zero-wait load, then a stalled store issued back-to-back in the done cycle.
        run_txn(1, 0, 32'h100, 32'h0, 4'hF, 0, 0, 0, 0, 32'hCAFEF00D, 0);
        chk("zw_load_data", dm_data_l_o, 32'hCAFEF00D);
        run_txn(0, 1, 32'h200, 32'h12345678, 4'b0011, 3, 2, 0, 0, 32'h0, 0);
        run_txn(1, 0, 32'h204, 32'h0, 4'hF, 0, 1, 0, 0, 32'h0BADF00D, 0);
        step();
        chk("idle_no_dup_pulse", 32'({dm_load_done_o, dm_store_done_o}), 0);

        // Sticky error capture and clear-versus-error priority.
        run_txn(1, 0, 32'hBAD0, 32'h0, 4'hF, 0, 1, 1, 0, 32'h55, 0);
        chk("err1_flag", 32'(bus_err_o), 1);
        chk("err1_addr", bus_err_addr_o, 32'hBAD0);
        run_txn(1, 0, 32'hBAD4, 32'h0, 4'hF, 1, 0, 1, 1, 32'h66, 0);
        chk("err2_addr_kept", bus_err_addr_o, 32'hBAD0);
        run_txn(1, 0, 32'hBAD8, 32'h0, 4'hF, 0, 2, 1, 0, 32'h77, 1);
        chk("err3_clr_addr", bus_err_addr_o, 32'hBAD8);
        bus_err_clr_i = 1'b1;
        step();
        bus_err_clr_i = 1'b0;
        m_err = 1'b0;
        m_err_addr = 32'h0;
        step();
        chk("clr_flag", 32'(bus_err_o), 0);
        chk("clr_addr", bus_err_addr_o, 0);

        // Both strobes together: the store is carried out.
        run_txn(1, 1, 32'h300, 32'hA5A5A5A5, 4'b1100, 1, 1, 0, 0, 32'h0, 0);
        step();

        for (int n = 0; n < 150; n++) begin
            ld  = int'($urandom_range(0, 1));
            st  = int'($urandom_range(0, 1));
            if (ld == 0 && st == 0) ld = 1;
            s   = int'($urandom_range(0, 3));
            d   = int'($urandom_range(0, 3));
            er  = ($urandom_range(0, 4) == 0) ? 1 : 0;
            wa  = int'($urandom_range(0, 1));
            clr = ($urandom_range(0, 7) == 0) ? 1 : 0;
            run_txn(ld, st, {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom(),
                    4'($urandom_range(0, 15)), s, d, er, wa, $urandom(), clr);
            if ($urandom_range(0, 1) == 0) begin
                stray = int'($urandom_range(0, 2));
                wb_bus.wb_ack_i = (stray == 1);
                wb_bus.wb_err_i = (stray == 2);
                step();
                wb_bus.wb_ack_i = 1'b0;
                wb_bus.wb_err_i = 1'b0;
                chk("idle_pulse_end", 32'({dm_load_done_o, dm_store_done_o}), 0);
                step();
                chk("stray_no_done", 32'({dm_load_done_o, dm_store_done_o}), 0);
                chk("stray_ready", 32'(dm_ready_o), 1);
                chk("stray_cyc", 32'(wb_bus.wb_cyc_o), 0);
                chk("stray_bus_err", 32'(bus_err_o), 32'(m_err));
            end
        end
        step();

        // Unanswered transaction.
        bus_err_clr_i = 1'b1;
        step();
        bus_err_clr_i = 1'b0;
        m_err = 1'b0;
        m_err_addr = 32'h0;
        wb_bus.wb_dat_i = 32'hDEADBEEF;
        dm_addr_i = 32'h400;
        dm_load_i = 1'b1;
        step();
        dm_load_i = 1'b0;
`ifdef URV_DM_BRIDGE_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            chk("to_cyc_high", 32'(wb_bus.wb_cyc_o), 1);
            chk("to_no_done", 32'(dm_load_done_o), 0);
            step();
        end
        chk("to_cyc_drop", 32'(wb_bus.wb_cyc_o), 0);
        chk("to_load_done", 32'(dm_load_done_o), 1);
        chk("to_data", dm_data_l_o, 32'h0);
        chk("to_bus_err", 32'(bus_err_o), 1);
        chk("to_bus_err_addr", bus_err_addr_o, 32'h400);
        step();
        chk("to_pulse_end", 32'(dm_load_done_o), 0);
`else
        hold = 0;
        for (int k = 0; k < 1000; k++) begin
            if (wb_bus.wb_cyc_o && !dm_load_done_o) hold++;
            step();
        end
        chk("hold_cyc_cycles", 32'(hold), 1000);
        chk("hold_bus_err", 32'(bus_err_o), 0);
        rst_i = 1'b0;
        #1;
        chk("hold_rst_cyc", 32'(wb_bus.wb_cyc_o), 0);
        step();
        rst_i = 1'b1;
        step();
`endif

        // Reset while in WAIT, with a late ack after release.
        dm_addr_i = 32'h500;
        dm_load_i = 1'b1;
        step();
        dm_load_i = 1'b0;
        step();
        chk("rw_wait_cyc", 32'(wb_bus.wb_cyc_o), 1);
        chk("rw_wait_stb", 32'(wb_bus.wb_stb_o), 0);
        #2;
        rst_i = 1'b0;
        #1;
        chk("rw_async_cyc", 32'(wb_bus.wb_cyc_o), 0);
        chk("rw_async_stb", 32'(wb_bus.wb_stb_o), 0);
        chk("rw_async_ready", 32'(dm_ready_o), 1);
        step();
        rst_i = 1'b1;
        m_err = 1'b0;
        m_err_addr = 32'h0;
        wb_bus.wb_ack_i = 1'b1;
        wb_bus.wb_dat_i = 32'h13579BDF;
        step();
        wb_bus.wb_ack_i = 1'b0;
        chk("rw_late_ack_done", 32'({dm_load_done_o, dm_store_done_o}), 0);
        step();
        chk("rw_late_ack_done2", 32'({dm_load_done_o, dm_store_done_o}), 0);
        chk("rw_ready", 32'(dm_ready_o), 1);
        chk("rw_cyc", 32'(wb_bus.wb_cyc_o), 0);
        chk("rw_bus_err", 32'(bus_err_o), 32'(m_err));

        // Bridge still works after the reset.
        run_txn(0, 1, 32'h600, 32'hFEEDFACE, 4'hF, 0, 0, 0, 0, 32'h0, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
